fetch_controller: RTL and testbench



---
 rtl/mips_pkg.sv | 22 ++
 rtl/pc_next_sel.sv | 30 +++
 rtl/fetch_controller.sv | 95 +++++++++
 tb/tb_fetch_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch stage.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT,
    ST_ERROR
  } fetch_state_t;

  localparam logic [5:0]  OP_BEQ     = 6'b000100;
  localparam logic [31:0] NOP_WORD   = 32'h0;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Branch displacement in bytes: sign-extended word offset times four.
  function automatic logic [31:0] beq_offset(
    input logic [15:0] imm
  );
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: redirect, hold, early-beq target or sequential.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        beq_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        hazard_stall,
  output logic [31:0] pc_next
);

  logic [31:0] seq_pc;
  logic        unused_instr_hi;

  assign seq_pc          = pc + WORD_BYTES;
  assign unused_instr_hi = ^instr[31:16];

  always_comb begin
    pc_next = seq_pc;
    priority case (1'b1)
      branch_taken: pc_next = branch_target;
      hazard_stall: pc_next = pc;
      !beq_stall:   pc_next = seq_pc + beq_offset(instr[15:0]);
      default:      pc_next = seq_pc;
    endcase
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives IF/ID controls,
// detects end-of-program zero runs and out-of-range fetches.
module fetch_controller
  import mips_pkg::*;
#(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          HALT_NOPS  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        beq_stall,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        halted,
  output logic        range_err,
  output logic [15:0] fetch_count
);

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);
  localparam logic [3:0]  HALT_N  = 4'(HALT_NOPS);

  fetch_state_t state;
  logic [3:0]   zero_run;
  logic [3:0]   zr_next;
  logic [31:0]  pc_next;
  logic         run;
  logic         pc_bad;
  logic         accept;

  pc_next_sel u_sel (
    .pc            (pc),
    .instr         (instr),
    .beq_stall     (beq_stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .hazard_stall  (hazard_stall),
    .pc_next       (pc_next)
  );

  assign run    = (state == ST_RUN);
  assign pc_bad = (pc[1:0] != 2'b00) ||
                  ({2'b00, pc[31:2]} >= DEPTH_W);
  assign accept = reset_n && run && !pc_bad &&
                  !branch_taken && !hazard_stall;

  assign zr_next = (instr == NOP_WORD) ? zero_run + 4'd1 : 4'd0;

  assign ifid_write = accept;
  assign ifid_flush = !reset_n || !run || pc_bad || branch_taken;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      zero_run    <= 4'd0;
      fetch_count <= 16'd0;
      halted      <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      unique case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          // A bad address wins over any redirect in the same cycle.
          if (pc_bad) begin
            state     <= ST_ERROR;
            range_err <= 1'b1;
          end else begin
            pc <= pc_next;
            if (branch_taken)
              zero_run <= 4'd0;
            if (accept) begin
              zero_run <= zr_next;
              if (fetch_count != 16'hFFFF)
                fetch_count <= fetch_count + 16'd1;
              if (zr_next == HALT_N) begin
                state  <= ST_HALT;
                halted <= 1'b1;
              end
            end
          end
        end
        ST_HALT:  state <= ST_HALT;
        ST_ERROR: state <= ST_ERROR;
        default:  state <= ST_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table plus
// randomized traffic against an event-level reference model.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        beq_stall;
  logic        hazard_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ifid_write;
  logic        ifid_flush;
  logic        halted;
  logic        range_err;
  logic [15:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_controller dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc            (pc),
    .instr         (instr),
    .beq_stall     (beq_stall),
    .hazard_stall  (hazard_stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .halted        (halted),
    .range_err     (range_err),
    .fetch_count   (fetch_count)
  );

  typedef struct {
    logic        rst_n;
    logic [31:0] ins;
    logic        bs;
    logic        hz;
    logic        bt;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_wr;
    logic        e_fl;
    logic        e_halt;
    logic        e_rerr;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t mk(
    input logic rst_n, input logic [31:0] ins,
    input logic bs, input logic hz, input logic bt,
    input logic [31:0] tgt, input logic [31:0] e_pc,
    input logic e_wr, input logic e_fl, input logic e_halt,
    input logic e_rerr, input logic [15:0] e_cnt
  );
    vec_t v;
    v.rst_n = rst_n; v.ins = ins; v.bs = bs; v.hz = hz;
    v.bt = bt; v.tgt = tgt; v.e_pc = e_pc; v.e_wr = e_wr;
    v.e_fl = e_fl; v.e_halt = e_halt; v.e_rerr = e_rerr;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] i,
                       input logic bs, input logic hz,
                       input logic bt, input logic [31:0] t);
    reset_n       = r;
    instr         = i;
    beq_stall     = bs;
    hazard_stall  = hz;
    branch_taken  = bt;
    branch_target = t;
  endtask

  // Reference model: mode 0=boot 1=run 2=halt 3=error
  int          m_mode;
  logic [31:0] m_pc;
  int          m_zr;
  int          m_cnt;
  bit          m_halt;
  bit          m_rerr;

  task automatic model_step(input logic r, input logic [31:0] i,
                            input logic bs, input logic hz,
                            input logic bt, input logic [31:0] t,
                            output bit e_wr, output bit e_fl);
    bit bad;
    e_wr = 0;
    e_fl = 1;
    if (!r) begin
      m_mode = 0; m_pc = 32'h0; m_zr = 0; m_cnt = 0;
      m_halt = 0; m_rerr = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      bad = (m_pc % 4 != 0) || (m_pc / 4 >= 64);
      if (bad) begin
        m_mode = 3;
        m_rerr = 1;
      end else if (bt) begin
        m_pc = t;
        m_zr = 0;
      end else if (hz) begin
        e_fl = 0;
      end else begin
        e_wr = 1;
        e_fl = 0;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        m_zr = (i == 0) ? m_zr + 1 : 0;
        if (bs) m_pc = m_pc + 32'd4;
        else m_pc = m_pc + 32'd4 + 32'($signed(i[15:0]) * 4);
        if (m_zr == 4) begin
          m_mode = 2;
          m_halt = 1;
        end
      end
    end
  endtask

  localparam logic [31:0] I_ADD = 32'h01095020;
  localparam logic [31:0] I_BEQ = 32'h11290003;

  initial begin
    bit          e_wr, e_fl;
    int          stuck;
    logic        r, bs, hz, bt;
    logic [31:0] ins, tgt;

    tbl[0]  = mk(0, I_ADD, 1, 0, 0, 0, 32'h00, 0, 1, 0, 0, 0);
    tbl[1]  = mk(1, I_ADD, 1, 0, 0, 0, 32'h00, 0, 1, 0, 0, 0);
    tbl[2]  = mk(1, I_ADD, 1, 0, 0, 0, 32'h00, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1, I_ADD, 1, 0, 0, 0, 32'h04, 1, 0, 0, 0, 1);
    tbl[4]  = mk(1, I_ADD, 1, 1, 0, 0, 32'h08, 0, 0, 0, 0, 2);
    tbl[5]  = mk(1, I_ADD, 1, 1, 0, 0, 32'h08, 0, 0, 0, 0, 2);
    tbl[6]  = mk(1, I_ADD, 1, 0, 0, 0, 32'h08, 1, 0, 0, 0, 2);
    tbl[7]  = mk(1, I_ADD, 1, 0, 0, 0, 32'h0C, 1, 0, 0, 0, 3);
    tbl[8]  = mk(1, I_BEQ, 0, 0, 0, 0, 32'h10, 1, 0, 0, 0, 4);
    tbl[9]  = mk(1, 32'h0, 1, 0, 0, 0, 32'h20, 1, 0, 0, 0, 5);
    tbl[10] = mk(1, 32'h0, 1, 0, 0, 0, 32'h24, 1, 0, 0, 0, 6);
    tbl[11] = mk(1, 32'h0, 1, 1, 1, 32'h40, 32'h28, 0, 1, 0, 0, 7);
    tbl[12] = mk(1, 32'h0, 1, 0, 0, 0, 32'h40, 1, 0, 0, 0, 7);
    tbl[13] = mk(1, 32'h0, 1, 0, 0, 0, 32'h44, 1, 0, 0, 0, 8);
    tbl[14] = mk(1, 32'h0, 1, 0, 0, 0, 32'h48, 1, 0, 0, 0, 9);
    tbl[15] = mk(1, 32'h0, 1, 0, 0, 0, 32'h4C, 1, 0, 0, 0, 10);
    tbl[16] = mk(1, 32'h0, 1, 0, 1, 32'h0, 32'h50, 0, 1, 1, 0, 11);
    tbl[17] = mk(1, I_ADD, 0, 0, 1, 32'h8, 32'h50, 0, 1, 1, 0, 11);
    tbl[18] = mk(0, I_ADD, 1, 0, 1, 32'h8, 32'h50, 0, 1, 1, 0, 11);
    tbl[19] = mk(1, I_ADD, 1, 0, 0, 0, 32'h00, 0, 1, 0, 0, 0);
    tbl[20] = mk(1, I_ADD, 1, 0, 1, 32'h100, 32'h00, 0, 1, 0, 0, 0);
    tbl[21] = mk(1, I_ADD, 1, 0, 0, 0, 32'h100, 0, 1, 0, 0, 0);
    tbl[22] = mk(1, I_ADD, 1, 0, 1, 32'h0, 32'h100, 0, 1, 0, 1, 0);
    tbl[23] = mk(0, I_ADD, 1, 0, 0, 0, 32'h100, 0, 1, 0, 1, 0);
    tbl[24] = mk(1, I_ADD, 1, 0, 0, 0, 32'h00, 0, 1, 0, 0, 0);
    tbl[25] = mk(1, I_ADD, 1, 0, 1, 32'h42, 32'h00, 0, 1, 0, 0, 0);
    tbl[26] = mk(1, I_ADD, 1, 0, 0, 0, 32'h42, 0, 1, 0, 0, 0);
    tbl[27] = mk(1, I_ADD, 1, 0, 0, 0, 32'h42, 0, 1, 0, 1, 0);
    tbl[28] = mk(0, I_ADD, 1, 0, 0, 0, 32'h42, 0, 1, 0, 1, 0);
    tbl[29] = mk(1, I_ADD, 1, 0, 0, 0, 32'h00, 0, 1, 0, 0, 0);

    drive(0, 32'h0, 1, 0, 0, 32'h0);
    repeat (2) @(posedge clk);

    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      drive(tbl[k].rst_n, tbl[k].ins, tbl[k].bs, tbl[k].hz,
            tbl[k].bt, tbl[k].tgt);
      #1;
      chk($sformatf("vec%0d pc", k), pc, tbl[k].e_pc);
      chk($sformatf("vec%0d ifid_write", k),
          32'(ifid_write), 32'(tbl[k].e_wr));
      chk($sformatf("vec%0d ifid_flush", k),
          32'(ifid_flush), 32'(tbl[k].e_fl));
      chk($sformatf("vec%0d halted", k),
          32'(halted), 32'(tbl[k].e_halt));
      chk($sformatf("vec%0d range_err", k),
          32'(range_err), 32'(tbl[k].e_rerr));
      chk($sformatf("vec%0d fetch_count", k),
          32'(fetch_count), 32'(tbl[k].e_cnt));
    end

    // Last vector left the DUT leaving BOOT with PC at reset value.
    m_mode = 1; m_pc = 32'h0; m_zr = 0; m_cnt = 0;
    m_halt = 0; m_rerr = 0;
    stuck = 0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r = !(($urandom_range(0, 199) == 0) || stuck > 12);
      ins = ($urandom_range(0, 99) < 45) ? 32'h0 : $urandom;
      bs = ($urandom_range(0, 99) < 12) ? 1'b0 : 1'b1;
      if (!bs)
        ins = {6'b000100, 10'h129,
               16'($signed($urandom_range(0, 12)) - 6)};
      hz = ($urandom_range(0, 99) < 15);
      bt = ($urandom_range(0, 99) < 8);
      tgt = ($urandom_range(0, 99) < 85) ?
            32'($urandom_range(0, 63) * 4) : $urandom;
      drive(r, ins, bs, hz, bt, tgt);
      #1;
      chk("rnd pc", pc, m_pc);
      chk("rnd halted", 32'(halted), 32'(m_halt));
      chk("rnd range_err", 32'(range_err), 32'(m_rerr));
      chk("rnd fetch_count", 32'(fetch_count), 32'(m_cnt));
      model_step(r, ins, bs, hz, bt, tgt, e_wr, e_fl);
      chk("rnd ifid_write", 32'(ifid_write), 32'(e_wr));
      chk("rnd ifid_flush", 32'(ifid_flush), 32'(e_fl));
      stuck = (m_mode >= 2) ? stuck + 1 : 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
